board_write_arb: RTL and testbench
==================================

# board_write_arb

Merges tile-write requests from the sprite updaters (Pac-Man, ghosts) into the single write port of the board tile RAM, downstream of each updater's `wren`/`write_addr`/`write_data` outputs. Each source gets a small FIFO so that back-to-back clear/draw pairs are never lost when two sources write in the same cycle. A round-robin arbiter drains one entry per cycle into registered RAM write outputs.

## Interface
- `N_SRC`, 2: number of write sources. Index 0 is Pac-Man; 1.. are ghosts.
- `DEPTH`, 4: entries per source FIFO. Must be a power of two, ≥2.
- `clk` input 1: single clock. Everything is clocked on the rising edge.
- `reset` input 1: synchronous, active-high.
- `src_wren` input N_SRC: per-source write strobe. One request per cycle per high bit.
- `src_addr` input N_SRC*10: packed tile addresses. Source i occupies bits [i*10+9 : i*10].
- `src_data` input N_SRC*4: packed tile codes. Source i occupies bits [i*4+3 : i*4].
- `stall` input 1: when high, no FIFO is popped that cycle.
- `ram_wren` output 1: registered write enable to the board RAM.
- `ram_addr` output 10: registered RAM write address.
- `ram_data` output 4: registered RAM write data.
- `src_full` output N_SRC: combinational; high when source i's FIFO holds DEPTH entries.
- `overflow` output N_SRC: sticky; set when a request from source i is dropped.
- `idle` output 1: registered; high when all FIFOs are empty and `ram_wren` is 0.

## Operation
- **Push.** A source's request is accepted at the edge if its FIFO count is below DEPTH, or if the FIFO is full and is popped at that same edge.
  - Otherwise the request is dropped and `overflow[i]` is set.
  - `overflow` bits are cleared only by `reset`.
- **Grant.** The grant is computed combinationally from the non-empty FIFOs and `last_grant`.
  - The selected source is the first non-empty index strictly after `last_grant`, searching cyclically.
  - No grant is made when `stall` is high or all FIFOs are empty.
- **Pop.** When a grant is made, the granted FIFO head is popped at the edge.
  - At the same edge, `ram_wren`←1, `ram_addr`/`ram_data`←head, and `last_grant`←granted index.
  - With no grant: `ram_wren`←0, and `ram_addr`/`ram_data` hold their previous values.
- **Ordering.** Writes from a single source reach RAM in issue order. Cross-source order follows the grant sequence only; no address hazard checking is done.
- **Arbiter states.**
  - IDLE: no FIFO non-empty. Goes to DRAIN when any FIFO becomes non-empty.
  - DRAIN: one pop per unstalled cycle. Returns to IDLE when the last entry pops and no push arrives at the same edge.
  - `idle` = (state == IDLE) && !ram_wren.
- **Pointers.** FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
  - Push to an empty FIFO together with no pop: count 0→1.
  - Push and pop at the same edge: count unchanged.

## Timing
- A request sampled at edge t is granted no earlier than edge t+1. `ram_wren` is therefore high in the cycle after edge t+1, giving a minimum latency of 2 edges.
- Throughput is one RAM write per unstalled cycle, shared across all sources.
- Worst-case wait for a source's head entry is N_SRC−1 grants. No source starves.
- `stall` asserted at edge t means no pop at t, and `ram_wren` is 0 in the following cycle. Pushes continue during stall.
- **Reset values** (applied at the edge where `reset` is high):
  - All FIFOs empty.
  - `ram_wren`=0, `ram_addr`=0, `ram_data`=0.
  - `overflow`=0, `last_grant`=N_SRC−1, so source 0 wins first.
  - State IDLE, `idle`=1.
  - Requests presented in the reset cycle are discarded, even mid-drain.

## Structure
- `board_pkg` holds `ADDR_W`=10 and `DATA_W`=4.
- It also holds the tile codes: `TILE_EMPTY`=4'b0000 and `TILE_PAC`=4'b0011, with ghost codes allocated 4'b0100 upward.
- Sub-module `tile_wr_fifo`:
  - Parameterised by DEPTH; one instance per source via a generate loop.
  - Ports: `push`, `pop`, `din[13:0]`, `dout`, `count`, `full`, `empty`.
  - FIFO storage is flops, not block RAM.
- Round-robin grant logic lives in the top level.

## Test plan
- **Single source.** Source 0 issues (addr 10'd37, data 0) at t, then (10'd38, 4'b0011) at t+1 → RAM writes 37/0 in the cycle after t+1, then 38/3 in the next cycle; `idle` returns to 1 afterwards.
- **Simultaneous.** Sources 0 and 1 request addr 5/data 3 and addr 6/data 4 at the same edge, straight after reset → RAM writes 5/3, then 6/4, on consecutive cycles.
- **Fairness.** Both sources push continuously for 8 cycles → grants alternate 0,1,0,1…; no overflow occurs while each source's push rate is ≤ 1 per 2 cycles.
- **Overflow.** `stall`=1 while source 1 pushes DEPTH+1=5 entries → `src_full[1]`=1 after the 4th push, the 5th is dropped and `overflow[1]`=1. Releasing `stall` drains exactly 4 writes in order, and `overflow[1]` stays 1.
- **Full with pop.** With a FIFO full and unstalled, a push at the same edge as a pop is accepted → count stays at 4 and no overflow is flagged.
- **Reset mid-drain.** Assert `reset` with 3 entries pending → next cycle `ram_wren`=0, `idle`=1, `overflow`=0, and no stale writes appear after reset is released.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: shared widths, tile codes and types for the board tile-RAM
// write path.
//   ADDR_W / DATA_W : tile RAM address and tile-code widths
//   TILE_*          : tile codes (ghost codes count up from TILE_GHOST0)
//   wr_req_t        : one queued tile write {addr, data}
//   arb_state_t     : write arbiter state
package board_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;
  localparam int REQ_W  = ADDR_W + DATA_W;

  localparam logic [DATA_W-1:0] TILE_EMPTY  = 4'b0000;
  localparam logic [DATA_W-1:0] TILE_PAC    = 4'b0011;
  localparam logic [DATA_W-1:0] TILE_GHOST0 = 4'b0100;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {ARB_IDLE, ARB_DRAIN} arb_state_t;
endpackage

// File: rtl/tile_wr_fifo.sv
// tile_wr_fifo: small flop-based FIFO holding pending tile writes for one
// source.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push, pop  : enqueue din / dequeue head (same-edge push+pop allowed)
//   din, dout  : {addr, data} in, head entry out
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module tile_wr_fifo
  import board_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REQ_W-1:0]         din,
  output logic [REQ_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [REQ_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when its head leaves at the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/board_write_arb.sv
// board_write_arb: merges per-sprite tile writes into the single board RAM
// write port. Each source is buffered in a tile_wr_fifo; a round-robin
// arbiter drains one entry per unstalled cycle into registered RAM outputs.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   src_wren/addr/data  : packed per-source write requests (0 = Pac-Man)
//   stall               : blocks all pops this cycle
//   ram_wren/addr/data  : registered RAM write port
//   src_full            : per-source FIFO full (combinational)
//   overflow            : sticky per-source dropped-request flag
//   idle                : registered; nothing queued and no write in flight
module board_write_arb
  import board_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC-1:0]          src_wren,
  input  logic [N_SRC*ADDR_W-1:0]   src_addr,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  input  logic                      stall,
  output logic                      ram_wren,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic [N_SRC-1:0]          src_full,
  output logic [N_SRC-1:0]          overflow,
  output logic                      idle
);
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0]          push, pop, empty, full;
  logic [N_SRC-1:0][CW-1:0]  count;
  wr_req_t [N_SRC-1:0]       head;

  arb_state_t        state_q, state_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [N_SRC-1:0]  overflow_q, overflow_d;
  logic              idle_q, idle_d;

  logic              gnt_vld;
  logic [GW-1:0]     gnt_idx;
  logic              any_left;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    wr_req_t req;
    assign req     = '{addr: src_addr[g*ADDR_W +: ADDR_W], data: src_data[g*DATA_W +: DATA_W]};
    assign push[g] = src_wren[g] && (!full[g] || pop[g]);
    assign pop[g]  = gnt_vld && (gnt_idx == GW'(g));

    tile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (req),
      .dout  (head[g]),
      .count (count[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Round robin: first non-empty source strictly after last_grant, cyclically.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    if (!stall) begin
      for (int k = 1; k <= N_SRC; k++) begin
        idx = (int'(last_grant_q) + k) % N_SRC;
        if (!gnt_vld && !empty[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = GW'(idx);
        end
      end
    end
  end

  always_comb begin
    ram_wren_d   = gnt_vld;
    ram_addr_d   = gnt_vld ? head[gnt_idx].addr : ram_addr_q;
    ram_data_d   = gnt_vld ? head[gnt_idx].data : ram_data_q;
    last_grant_d = gnt_vld ? gnt_idx : last_grant_q;
    overflow_d   = overflow_q | (src_wren & full & ~pop);

    // Occupancy after this edge decides whether the arbiter has work left.
    any_left = 1'b0;
    for (int i = 0; i < N_SRC; i++)
      any_left |= ((count[i] + CW'(push[i]) - CW'(pop[i])) != '0);

    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (any_left)  state_d = ARB_DRAIN;
      ARB_DRAIN: if (!any_left) state_d = ARB_IDLE;
      default:                  state_d = ARB_IDLE;
    endcase
    idle_d = (state_d == ARB_IDLE) && !ram_wren_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      ram_wren_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      last_grant_q <= GW'(N_SRC - 1);
      overflow_q   <= '0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ram_wren_q   <= ram_wren_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      idle_q       <= idle_d;
    end
  end

  assign ram_wren = ram_wren_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign src_full = full;
  assign overflow = overflow_q;
  assign idle     = idle_q;
endmodule

// File: tb/tb_board_write_arb.sv
// Bench for board_write_arb: a hand-derived vector table, directed corner
// sequences, then random traffic, all checked against a queue-based model.
module tb_board_write_arb;
  import board_pkg::*;
  localparam int N = 2;
  localparam int D = 4;

  logic          clk, reset, stall;
  logic [N-1:0]  src_wren;
  logic [N*10-1:0] src_addr;
  logic [N*4-1:0]  src_data;
  logic          ram_wren, idle;
  logic [9:0]    ram_addr;
  logic [3:0]    ram_data;
  logic [N-1:0]  src_full, overflow;

  board_write_arb #(.N_SRC(N), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .src_wren(src_wren), .src_addr(src_addr),
    .src_data(src_data), .stall(stall), .ram_wren(ram_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .src_full(src_full),
    .overflow(overflow), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per source plus the RAM port registers.
  logic [13:0] q0[$];
  logic [13:0] q1[$];
  int          lg;
  logic        mw;
  logic [9:0]  ma;
  logic [3:0]  md;
  logic [1:0]  mov;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int qs(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic model_edge();
    int g;
    logic [13:0] e;
    if (reset) begin
      q0.delete(); q1.delete();
      lg = N - 1; mw = 0; ma = 0; md = 0; mov = 0;
    end else begin
      g = -1;
      if (!stall)
        for (int k = 1; k <= N; k++)
          if (g < 0 && qs((lg + k) % N) > 0) g = (lg + k) % N;
      if (g >= 0) begin
        e  = (g == 0) ? q0.pop_front() : q1.pop_front();
        mw = 1; ma = e[13:4]; md = e[3:0]; lg = g;
      end else mw = 0;
      for (int i = 0; i < N; i++)
        if (src_wren[i]) begin
          e = {src_addr[i*10 +: 10], src_data[i*4 +: 4]};
          if (qs(i) < D) begin
            if (i == 0) q0.push_back(e); else q1.push_back(e);
          end else mov[i] = 1;
        end
    end
  endtask

  task automatic check_all();
    chk("ram_wren", ram_wren, mw);
    chk("ram_addr", ram_addr, ma);
    chk("ram_data", ram_data, md);
    chk("idle", idle, (q0.size() == 0 && q1.size() == 0 && !mw));
    chk("src_full", src_full, {qs(1) == D, qs(0) == D});
    chk("overflow", overflow, mov);
  endtask

  task automatic step(input logic r, input logic [1:0] w, input logic [9:0] a0,
                      input logic [3:0] d0, input logic [9:0] a1, input logic [3:0] d1,
                      input logic st);
    @(negedge clk);
    reset = r; src_wren = w; src_addr = {a1, a0}; src_data = {d1, d0}; stall = st;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic nop(input logic st);
    step(1'b0, 2'b00, 10'd0, 4'd0, 10'd0, 4'd0, st);
  endtask

  typedef struct {
    logic       r;
    logic [1:0] w;
    logic [9:0] a0; logic [3:0] d0;
    logic [9:0] a1; logic [3:0] d1;
    logic       st;
    logic       ew; logic [9:0] ea; logic [3:0] ed; logic ei;
  } vec_t;

  vec_t tbl[10];
  int   nwr, prev_d;

  initial begin
    reset = 1'b1; stall = 1'b0; src_wren = '0; src_addr = '0; src_data = '0;
    lg = N - 1; mw = 0; ma = 0; md = 0; mov = 0;

    // Single source, then simultaneous requests straight after reset.
    tbl[0] = '{1'b1, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b1};
    tbl[1] = '{1'b0, 2'b01, 10'd37, 4'd0, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0};
    tbl[2] = '{1'b0, 2'b01, 10'd38, 4'd3, 10'd0, 4'd0, 1'b0, 1'b1, 10'd37, 4'd0, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b1, 10'd38, 4'd3, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b0, 10'd38, 4'd3, 1'b1};
    tbl[5] = '{1'b1, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0,  4'd0, 1'b1};
    tbl[6] = '{1'b0, 2'b11, 10'd5,  4'd3, 10'd6, 4'd4, 1'b0, 1'b0, 10'd0,  4'd0, 1'b0};
    tbl[7] = '{1'b0, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b1, 10'd5,  4'd3, 1'b0};
    tbl[8] = '{1'b0, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b1, 10'd6,  4'd4, 1'b0};
    tbl[9] = '{1'b0, 2'b00, 10'd0,  4'd0, 10'd0, 4'd0, 1'b0, 1'b0, 10'd6,  4'd4, 1'b1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].st);
      chk($sformatf("tbl%0d_wren", i), ram_wren, tbl[i].ew);
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_data", i), ram_data, tbl[i].ed);
      chk($sformatf("tbl%0d_idle", i), idle, tbl[i].ei);
    end

    // Fairness: both sources push every other cycle; grants must alternate.
    step(1'b1, 2'b00, 10'd0, 4'd0, 10'd0, 4'd0, 1'b0);
    prev_d = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 16 && c % 2 == 0)
        step(1'b0, 2'b11, 10'(c), TILE_PAC, 10'(100 + c), TILE_GHOST0, 1'b0);
      else nop(1'b0);
      if (ram_wren) begin
        if (prev_d >= 0) chk("fair_alternate", (int'(ram_data) != prev_d), 1);
        prev_d = int'(ram_data);
      end
    end
    chk("fair_no_overflow", overflow, 2'b00);

    // Overflow: stalled source 1 pushes DEPTH+1 entries.
    step(1'b1, 2'b00, 10'd0, 4'd0, 10'd0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b10, 10'd0, 4'd0, 10'(200 + k), 4'(k), 1'b1);
      if (k == 3) chk("ovf_full_after4", src_full[1], 1'b1);
      if (k == 3) chk("ovf_clear_after4", overflow[1], 1'b0);
    end
    chk("ovf_set", overflow[1], 1'b1);
    nwr = 0;
    for (int k = 0; k < 7; k++) begin
      nop(1'b0);
      if (ram_wren) begin
        chk("ovf_order", ram_addr, 10'(200 + nwr));
        nwr++;
      end
    end
    chk("ovf_drain_count", nwr, 4);
    chk("ovf_sticky", overflow[1], 1'b1);

    // Full FIFO accepts a push at the edge it is popped.
    step(1'b1, 2'b00, 10'd0, 4'd0, 10'd0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 2'b01, 10'(300 + k), 4'(k), 10'd0, 4'd0, 1'b1);
    chk("fwp_full_before", src_full[0], 1'b1);
    step(1'b0, 2'b01, 10'd304, 4'd4, 10'd0, 4'd0, 1'b0);
    chk("fwp_full_after", src_full[0], 1'b1);
    chk("fwp_no_overflow", overflow[0], 1'b0);
    for (int k = 0; k < 6; k++) nop(1'b0);

    // Reset with 3 entries pending, requests in the reset cycle discarded.
    for (int k = 0; k < 3; k++) step(1'b0, 2'b01, 10'(400 + k), 4'd1, 10'd0, 4'd0, 1'b1);
    step(1'b1, 2'b11, 10'd500, 4'd2, 10'd501, 4'd3, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_overflow", overflow, 2'b00);
    for (int k = 0; k < 4; k++) begin
      nop(1'b0);
      chk("rst_no_stale", ram_wren, 1'b0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 99) < 2), 2'($urandom), 10'($urandom), 4'($urandom),
           10'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
